// File: rtl/multicore_pkg.sv
// Shared types and bus widths for the multicore top level (cores, L2, memory arbiter).
package multicore_pkg;

   localparam int DATA_W = 64;
   localparam int ADDR_W = 64;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request scanning upward from last_grant+1, wrapping.
// Zero latency; found=0 when no request is set.
module rr_pick #(
   parameter int NCORES = 4,
   parameter int IW     = 2
) (
   input  logic [NCORES-1:0] req,
   input  logic [IW-1:0]     last_grant,
   output logic [NCORES-1:0] gnt,
   output logic              found
);

   int idx;

   always_comb begin
      gnt   = '0;
      found = 1'b0;
      idx   = 0;
      for (int k = 1; k <= NCORES; k++) begin
         idx = (int'(last_grant) + k) % NCORES;
         if (!found && req[idx]) begin
            gnt[idx] = 1'b1;
            found    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/shared_mem_arbiter.sv
// Round-robin arbiter for the single memory port: grant after 1 edge, response 1 edge after mem_ready.
// Requests wait (no req_ready) while an access is in flight; stuck accesses abort after TIMEOUT cycles.
module shared_mem_arbiter #(
   parameter int NCORES  = 4,
   parameter int DATA_W  = multicore_pkg::DATA_W,
   parameter int ADDR_W  = multicore_pkg::ADDR_W,
   parameter int TIMEOUT = 255
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [NCORES-1:0]        req_valid,
   input  logic [NCORES-1:0]        req_write,
   input  logic [NCORES*ADDR_W-1:0] req_addr,
   input  logic [NCORES*DATA_W-1:0] req_wdata,
   output logic [NCORES-1:0]        req_ready,
   output logic [NCORES-1:0]        resp_valid,
   output logic                     resp_err,
   output logic [DATA_W-1:0]        resp_rdata,
   output logic                     mem_valid,
   output logic                     mem_rw,
   output logic [ADDR_W-1:0]        mem_address,
   output logic [DATA_W-1:0]        mem_dataout,
   input  logic [DATA_W-1:0]        mem_datain,
   input  logic                     mem_ready
);
   import multicore_pkg::*;

   localparam int            IW       = (NCORES > 1) ? $clog2(NCORES) : 1;
   localparam logic [IW-1:0] LAST_RST = IW'(NCORES - 1);

   arb_state_t          state, nxt_state;
   logic [IW-1:0]       last_grant, nxt_last_grant;
   logic [7:0]          wait_cnt, nxt_wait_cnt, cnt_inc;
   logic [NCORES-1:0]   nxt_req_ready, nxt_resp_valid;
   logic                nxt_resp_err, nxt_mem_valid, nxt_mem_rw;
   logic [DATA_W-1:0]   nxt_resp_rdata, nxt_mem_dataout;
   logic [ADDR_W-1:0]   nxt_mem_address;

   logic [NCORES-1:0]   win_oh;
   logic                win_found;
   logic [IW-1:0]       win_idx;

   rr_pick #(
      .NCORES (NCORES),
      .IW     (IW)
   ) u_pick (
      .req        (req_valid),
      .last_grant (last_grant),
      .gnt        (win_oh),
      .found      (win_found)
   );

   always_comb begin
      win_idx = '0;
      for (int i = 0; i < NCORES; i++) begin
         if (win_oh[i]) win_idx = IW'(i);
      end
   end

   // saturating so a very large TIMEOUT can never wrap the counter back to a small value
   assign cnt_inc = (wait_cnt == 8'hFF) ? wait_cnt : wait_cnt + 8'd1;

   always_comb begin
      nxt_state       = state;
      nxt_last_grant  = last_grant;
      nxt_wait_cnt    = wait_cnt;
      nxt_req_ready   = '0;
      nxt_resp_valid  = '0;
      nxt_resp_err    = 1'b0;
      nxt_resp_rdata  = resp_rdata;
      nxt_mem_valid   = mem_valid;
      nxt_mem_rw      = mem_rw;
      nxt_mem_address = mem_address;
      nxt_mem_dataout = mem_dataout;
      case (state)
         IDLE: begin
            nxt_mem_valid = 1'b0;
            if (win_found) begin
               nxt_mem_address = req_addr[win_idx*ADDR_W +: ADDR_W];
               nxt_mem_dataout = req_wdata[win_idx*DATA_W +: DATA_W];
               nxt_mem_rw      = req_write[win_idx];
               nxt_mem_valid   = 1'b1;
               nxt_req_ready   = win_oh;
               nxt_last_grant  = win_idx;
               nxt_wait_cnt    = 8'd0;
               nxt_state       = BUSY;
            end
         end
         BUSY: begin
            // mem_ready is checked first so it wins a tie with the timeout
            if (mem_ready) begin
               nxt_mem_valid  = 1'b0;
               nxt_resp_valid = NCORES'(1) << last_grant;
               if (!mem_rw) nxt_resp_rdata = mem_datain;
               nxt_state      = IDLE;
            end else begin
               nxt_wait_cnt = cnt_inc;
               if (cnt_inc == 8'(TIMEOUT)) begin
                  nxt_mem_valid  = 1'b0;
                  nxt_resp_valid = NCORES'(1) << last_grant;
                  nxt_resp_err   = 1'b1;
                  nxt_resp_rdata = '0;
                  nxt_state      = IDLE;
               end
            end
         end
         default: nxt_state = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         last_grant  <= LAST_RST;
         wait_cnt    <= 8'd0;
         req_ready   <= '0;
         resp_valid  <= '0;
         resp_err    <= 1'b0;
         resp_rdata  <= '0;
         mem_valid   <= 1'b0;
         mem_rw      <= 1'b0;
         mem_address <= '0;
         mem_dataout <= '0;
      end else begin
         state       <= nxt_state;
         last_grant  <= nxt_last_grant;
         wait_cnt    <= nxt_wait_cnt;
         req_ready   <= nxt_req_ready;
         resp_valid  <= nxt_resp_valid;
         resp_err    <= nxt_resp_err;
         resp_rdata  <= nxt_resp_rdata;
         mem_valid   <= nxt_mem_valid;
         mem_rw      <= nxt_mem_rw;
         mem_address <= nxt_mem_address;
         mem_dataout <= nxt_mem_dataout;
      end
   end

endmodule
